// File: rtl/src_frame_buf_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : src_frame_buf_if                                        |
// | Description : Upstream pixel stream, lenet core handshake and result  |
// |               bus of the double-buffered source frame store.          |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
interface src_frame_buf_if #(
   parameter int DW = 8,
   parameter int AW = 12
);
   // Upstream pixel stream
   logic          pix_valid;
   logic [DW-1:0] pix_data;
   logic          pix_ready;
   // lenet core control
   logic          go;
   logic          done;
   logic [5:0]    digit_in;
   // lenet core source read port
   logic [AW-1:0] aa;
   logic          cena;
   logic [DW-1:0] qa;
   // Classification result
   logic          result_valid;
   logic [5:0]    result_digit;
   logic [15:0]   frame_cnt;

   modport slave (
      input  pix_valid, pix_data, done, digit_in, aa, cena,
      output pix_ready, go, qa, result_valid, result_digit, frame_cnt
   );

   modport master (
      output pix_valid, pix_data, done, digit_in, aa, cena,
      input  pix_ready, go, qa, result_valid, result_digit, frame_cnt
   );
endinterface
`default_nettype wire

// File: rtl/src_frame_buf.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : src_frame_buf                                           |
// | Description : Two-bank source frame store. Loads streamed frames into |
// |               a free bank, starts lenet on each full bank, serves the |
// |               core reads and captures the classified digit.           |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module src_frame_buf #(
   parameter int DW        = 8,
   parameter int AW        = 12,
   parameter int FRAME_PIX = 1024
) (
   input  logic           clk,
   input  logic           rstn,
   src_frame_buf_if.slave bus
);
   // Low address bits that actually index a bank
   localparam int            c_iw        = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
   localparam logic [AW-1:0] c_last_addr = AW'(FRAME_PIX - 1);
   localparam logic [AW:0]   c_frame_pix = (AW+1)'(FRAME_PIX);

   typedef enum logic [1:0] {
      BK_EMPTY = 2'd0,
      BK_FULL  = 2'd1,
      BK_BUSY  = 2'd2
   } bank_st_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GO   = 2'd1,
      S_RUN  = 2'd2
   } fsm_st_t;

   logic [DW-1:0] r_mem [0:1][0:FRAME_PIX-1];
   bank_st_t      r_bank_st [0:1];
   logic          r_wbank;
   logic          r_rbank;
   logic [AW-1:0] r_wr_addr;
   fsm_st_t       r_state;
   fsm_st_t       w_state_nxt;
   logic          w_start;
   logic          w_finish;
   logic          w_wr_free;
   logic          w_wr_en;
   logic          w_rd_hit;
   logic          r_go;
   logic          r_result_valid;
   logic [5:0]    r_result_digit;
   logic [15:0]   r_frame_cnt;
   logic [DW-1:0] r_qa;

   // The write bank accepts pixels only while it is EMPTY; a frame being
   // filled keeps the bank EMPTY until its last pixel lands. No write may
   // slip into memory on an edge while reset is held.
   assign w_wr_free = (r_bank_st[r_wbank] == BK_EMPTY);
   assign w_wr_en   = bus.pix_valid && w_wr_free && rstn;
   assign w_rd_hit  = ({1'b0, bus.aa} < c_frame_pix);

   assign bus.pix_ready    = w_wr_free;
   assign bus.go           = r_go;
   assign bus.qa           = r_qa;
   assign bus.result_valid = r_result_valid;
   assign bus.result_digit = r_result_digit;
   assign bus.frame_cnt    = r_frame_cnt;

   // Pixel storage for both banks (contents survive reset)
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wbank][r_wr_addr[c_iw-1:0]] <= bus.pix_data;
      end
   end

   // Compute FSM state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Compute FSM next state: start on a FULL read bank, release it on done
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_bank_st[r_rbank] == BK_FULL) begin
               w_state_nxt = S_GO;
            end
         end
         S_GO: begin
            w_start     = 1'b1;
            w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (bus.done) begin
               w_finish    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Bank bookkeeping: the writer only moves its bank EMPTY->FULL and the
   // FSM only moves the read bank, so both can act in the same cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int b = 0; b < 2; b++) begin
            r_bank_st[b] <= BK_EMPTY;
         end
         r_wbank   <= 1'b0;
         r_rbank   <= 1'b0;
         r_wr_addr <= '0;
      end else begin
         if (w_wr_en) begin
            if (r_wr_addr == c_last_addr) begin
               r_wr_addr          <= '0;
               r_bank_st[r_wbank] <= BK_FULL;
               r_wbank            <= ~r_wbank;
            end else begin
               r_wr_addr <= r_wr_addr + 1'b1;
            end
         end
         if (w_start) begin
            r_bank_st[r_rbank] <= BK_BUSY;
         end
         if (w_finish) begin
            r_bank_st[r_rbank] <= BK_EMPTY;
            r_rbank            <= ~r_rbank;
         end
      end
   end

   // Start pulse and result capture
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_go           <= 1'b0;
         r_result_valid <= 1'b0;
         r_result_digit <= '0;
         r_frame_cnt    <= '0;
      end else begin
         r_go           <= w_start;
         r_result_valid <= w_finish;
         if (w_finish) begin
            r_result_digit <= bus.digit_in;
            r_frame_cnt    <= r_frame_cnt + 16'd1;
         end
      end
   end

   // Core read port: one-cycle latency, zero beyond the frame, hold when idle
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_qa <= '0;
      end else if (!bus.cena) begin
         r_qa <= w_rd_hit ? r_mem[r_rbank][bus.aa[c_iw-1:0]] : '0;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_src_frame_buf.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_src_frame_buf                                        |
// | Description : Self-checking bench for src_frame_buf. The model keeps  |
// |               resident frames as a byte queue (oldest frame first).   |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module tb_src_frame_buf;
   localparam int DW        = 8;
   localparam int AW        = 12;
   localparam int FRAME_PIX = 1024;

   logic       clk = 1'b0;
   logic       rstn;
   int         checks    = 0;
   int         errors    = 0;
   int         go_cnt    = 0;
   int         exp_cnt   = 0;
   logic [5:0] exp_digit = '0;
   logic [7:0] q_pix [$];
   logic [7:0] stage [FRAME_PIX];

   src_frame_buf_if #(.DW(DW), .AW(AW)) bus ();

   src_frame_buf #(.DW(DW), .AW(AW), .FRAME_PIX(FRAME_PIX)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Count go cycles, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.go === 1'b1) go_cnt++;
   end

   // Absolute time guard
   initial begin
      #3_000_000;
      $display("FAIL watchdog simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pixel(input logic [7:0] d);
      int waited = 0;
      bus.pix_valid = 1'b1;
      bus.pix_data  = d;
      while (bus.pix_ready !== 1'b1 && waited < 5000) begin
         tick();
         waited++;
      end
      if (bus.pix_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL push_timeout pix_ready got %b want 1", bus.pix_ready);
      end
      tick();
   endtask

   // kind 0: index pattern, 1: constant val, 2: random
   task automatic stream_frame(input int kind, input logic [7:0] val, input int gap_max,
                               input bit done_last, input logic [5:0] dig);
      for (int i = 0; i < FRAME_PIX; i++) begin
         logic [7:0] d;
         case (kind)
            0:       d = i[7:0];
            1:       d = val;
            default: d = 8'($urandom);
         endcase
         stage[i] = d;
         if (gap_max > 0) begin
            int g = $urandom_range(0, gap_max);
            bus.pix_valid = 1'b0;
            repeat (g) tick();
         end
         if (done_last && i == FRAME_PIX - 1) begin
            bus.done     = 1'b1;
            bus.digit_in = dig;
         end
         push_pixel(d);
      end
      bus.pix_valid = 1'b0;
      bus.done      = 1'b0;
      for (int i = 0; i < FRAME_PIX; i++) q_pix.push_back(stage[i]);
   endtask

   task automatic pop_frame();
      repeat (FRAME_PIX) void'(q_pix.pop_front());
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      bus.pix_valid = 1'b1; bus.pix_data = 8'hFF;
      bus.done = 1'b0; bus.digit_in = '0; bus.aa = '0; bus.cena = 1'b1;
      repeat (3) tick();
      checks++; if (bus.pix_ready !== 1'b1) begin errors++; $display("FAIL reset_pix_ready got %b want 1", bus.pix_ready); end
      checks++; if (bus.go !== 1'b0) begin errors++; $display("FAIL reset_go got %b want 0", bus.go); end
      checks++; if (bus.qa !== 8'h00) begin errors++; $display("FAIL reset_qa got %h want 00", bus.qa); end
      checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid got %b want 0", bus.result_valid); end
      checks++; if (bus.result_digit !== 6'd0) begin errors++; $display("FAIL reset_result_digit got %0d want 0", bus.result_digit); end
      checks++; if (bus.frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", bus.frame_cnt); end
      bus.pix_valid = 1'b0;
      rstn = 1'b1;
      tick();
      checks++; if (bus.pix_ready !== 1'b1) begin errors++; $display("FAIL release_pix_ready got %b want 1", bus.pix_ready); end
   endtask

   task automatic test_single_frame();
      int g0 = go_cnt;
      stream_frame(0, 8'h00, 0, 1'b0, 6'd0);
      tick();
      checks++; if (bus.go !== 1'b0) begin errors++; $display("FAIL single_go_k1 got %b want 0", bus.go); end
      tick();
      checks++; if (bus.go !== 1'b1) begin errors++; $display("FAIL single_go_k2 got %b want 1", bus.go); end
      tick();
      checks++; if (bus.go !== 1'b0) begin errors++; $display("FAIL single_go_k3 got %b want 0", bus.go); end
      checks++; if (bus.pix_ready !== 1'b1) begin errors++; $display("FAIL single_pix_ready got %b want 1", bus.pix_ready); end
      bus.aa = 12'd5; bus.cena = 1'b0;
      tick();
      checks++; if (bus.qa !== 8'd5) begin errors++; $display("FAIL single_qa5 got %h want 05", bus.qa); end
      bus.aa = 12'd1030;
      tick();
      checks++; if (bus.qa !== 8'd0) begin errors++; $display("FAIL single_qa_oob got %h want 00", bus.qa); end
      bus.aa = 12'd5; bus.cena = 1'b1;
      tick();
      checks++; if (bus.qa !== 8'd0) begin errors++; $display("FAIL single_qa_hold got %h want 00", bus.qa); end
      for (int n = 0; n < 6; n++) begin
         int a = $urandom_range(0, FRAME_PIX - 1);
         bus.aa = AW'(a); bus.cena = 1'b0;
         tick();
         checks++; if (bus.qa !== q_pix[a]) begin errors++; $display("FAIL single_qa_rand aa=%0d got %h want %h", a, bus.qa, q_pix[a]); end
      end
      bus.cena = 1'b1;
      checks++; if (go_cnt - g0 !== 1) begin errors++; $display("FAIL single_go_count got %0d want 1", go_cnt - g0); end
   endtask

   task automatic test_ping_pong();
      int g0 = go_cnt;
      int a;
      stream_frame(1, 8'hA5, 0, 1'b0, 6'd0);
      repeat (4) tick();
      checks++; if (go_cnt !== g0) begin errors++; $display("FAIL pp_no_go got %0d want %0d", go_cnt, g0); end
      checks++; if (bus.pix_ready !== 1'b0) begin errors++; $display("FAIL pp_full_ready got %b want 0", bus.pix_ready); end
      bus.pix_valid = 1'b1; bus.pix_data = 8'h11;
      repeat (5) tick();
      checks++; if (bus.pix_ready !== 1'b0) begin errors++; $display("FAIL pp_third_stall got %b want 0", bus.pix_ready); end
      bus.pix_valid = 1'b0;
      bus.done = 1'b1; bus.digit_in = 6'd7;
      tick();
      bus.done = 1'b0;
      exp_cnt++; exp_digit = 6'd7; pop_frame();
      checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL pp_result_valid got %b want 1", bus.result_valid); end
      checks++; if (bus.result_digit !== exp_digit) begin errors++; $display("FAIL pp_result_digit got %0d want %0d", bus.result_digit, exp_digit); end
      checks++; if (bus.frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL pp_frame_cnt got %0d want %0d", bus.frame_cnt, exp_cnt); end
      checks++; if (bus.pix_ready !== 1'b1) begin errors++; $display("FAIL pp_ready_after_done got %b want 1", bus.pix_ready); end
      tick();
      checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL pp_result_pulse got %b want 0", bus.result_valid); end
      checks++; if (bus.go !== 1'b0) begin errors++; $display("FAIL pp_go_k1 got %b want 0", bus.go); end
      tick();
      checks++; if (bus.go !== 1'b1) begin errors++; $display("FAIL pp_go_k2 got %b want 1", bus.go); end
      a = $urandom_range(0, FRAME_PIX - 1);
      bus.aa = AW'(a); bus.cena = 1'b0;
      tick();
      bus.cena = 1'b1;
      checks++; if (bus.qa !== 8'hA5) begin errors++; $display("FAIL pp_qa aa=%0d got %h want a5", a, bus.qa); end
   endtask

   task automatic test_simultaneous();
      logic [5:0] dig = 6'($urandom_range(0, 63));
      int a;
      stream_frame(2, 8'h00, 0, 1'b1, dig);
      exp_cnt++; exp_digit = dig; pop_frame();
      checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL sim_result_valid got %b want 1", bus.result_valid); end
      checks++; if (bus.result_digit !== exp_digit) begin errors++; $display("FAIL sim_result_digit got %0d want %0d", bus.result_digit, exp_digit); end
      checks++; if (bus.frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL sim_frame_cnt got %0d want %0d", bus.frame_cnt, exp_cnt); end
      checks++; if (bus.pix_ready !== 1'b1) begin errors++; $display("FAIL sim_pix_ready got %b want 1", bus.pix_ready); end
      tick();
      checks++; if (bus.go !== 1'b0) begin errors++; $display("FAIL sim_go_k1 got %b want 0", bus.go); end
      tick();
      checks++; if (bus.go !== 1'b1) begin errors++; $display("FAIL sim_go_k2 got %b want 1", bus.go); end
      a = $urandom_range(0, FRAME_PIX - 1);
      bus.aa = AW'(a); bus.cena = 1'b0;
      tick();
      bus.cena = 1'b1;
      checks++; if (bus.qa !== q_pix[a]) begin errors++; $display("FAIL sim_qa aa=%0d got %h want %h", a, bus.qa, q_pix[a]); end
      repeat (3) tick();
      dig = 6'($urandom_range(0, 63));
      bus.done = 1'b1; bus.digit_in = dig;
      tick();
      bus.done = 1'b0;
      exp_cnt++; exp_digit = dig; pop_frame();
      checks++; if (bus.frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL sim_drain_cnt got %0d want %0d", bus.frame_cnt, exp_cnt); end
   endtask

   task automatic test_spurious_done();
      int g0 = go_cnt;
      repeat (3) tick();
      bus.done = 1'b1; bus.digit_in = 6'd42;
      tick();
      checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL spur_result_valid got %b want 0", bus.result_valid); end
      tick();
      bus.done = 1'b0;
      tick();
      checks++; if (bus.frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL spur_frame_cnt got %0d want %0d", bus.frame_cnt, exp_cnt); end
      checks++; if (bus.result_digit !== exp_digit) begin errors++; $display("FAIL spur_result_digit got %0d want %0d", bus.result_digit, exp_digit); end
      checks++; if (go_cnt !== g0) begin errors++; $display("FAIL spur_go got %0d want %0d", go_cnt, g0); end
   endtask

   task automatic test_random_stream();
      int g0 = go_cnt;
      for (int it = 0; it < 5; it++) begin
         int keep;
         if (it < 4) begin
            logic exp_ready;
            stream_frame(2, 8'h00, 3, 1'b0, 6'd0);
            exp_ready = (q_pix.size() < 2 * FRAME_PIX);
            checks++; if (bus.pix_ready !== exp_ready) begin errors++; $display("FAIL rnd_pix_ready it=%0d got %b want %b", it, bus.pix_ready, exp_ready); end
         end
         keep = (it < 4) ? 2 * FRAME_PIX : FRAME_PIX;
         while (q_pix.size() >= keep) begin
            logic [5:0] dig;
            repeat (6) tick();
            for (int n = 0; n < 2; n++) begin
               int a = $urandom_range(0, FRAME_PIX - 1);
               bus.aa = AW'(a); bus.cena = 1'b0;
               tick();
               checks++; if (bus.qa !== q_pix[a]) begin errors++; $display("FAIL rnd_qa aa=%0d got %h want %h", a, bus.qa, q_pix[a]); end
            end
            bus.cena = 1'b1;
            dig = 6'($urandom_range(0, 63));
            bus.done = 1'b1; bus.digit_in = dig;
            tick();
            bus.done = 1'b0;
            exp_cnt++; exp_digit = dig; pop_frame();
            checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL rnd_result_valid got %b want 1", bus.result_valid); end
            checks++; if (bus.result_digit !== exp_digit) begin errors++; $display("FAIL rnd_result_digit got %0d want %0d", bus.result_digit, exp_digit); end
            checks++; if (bus.frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL rnd_frame_cnt got %0d want %0d", bus.frame_cnt, exp_cnt); end
         end
      end
      repeat (4) tick();
      checks++; if (go_cnt - g0 !== 4) begin errors++; $display("FAIL rnd_go_count got %0d want 4", go_cnt - g0); end
   endtask

   task automatic test_reset_midframe();
      int g0;
      for (int i = 0; i < 500; i++) push_pixel(8'($urandom));
      bus.pix_valid = 1'b0;
      rstn = 1'b0;
      tick();
      checks++; if (bus.frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset_cnt got %0d want 0", bus.frame_cnt); end
      checks++; if (bus.qa !== 8'h00) begin errors++; $display("FAIL mid_reset_qa got %h want 00", bus.qa); end
      checks++; if (bus.result_digit !== 6'd0) begin errors++; $display("FAIL mid_reset_digit got %0d want 0", bus.result_digit); end
      tick();
      rstn = 1'b1;
      q_pix.delete(); exp_cnt = 0; exp_digit = '0;
      tick();
      g0 = go_cnt;
      stream_frame(1, 8'h3C, 0, 1'b0, 6'd0);
      repeat (4) tick();
      checks++; if (go_cnt - g0 !== 1) begin errors++; $display("FAIL mid_go_count got %0d want 1", go_cnt - g0); end
      bus.aa = 12'd0; bus.cena = 1'b0;
      tick();
      checks++; if (bus.qa !== 8'h3C) begin errors++; $display("FAIL mid_qa0 got %h want 3c", bus.qa); end
      bus.aa = 12'd1023;
      tick();
      bus.cena = 1'b1;
      checks++; if (bus.qa !== 8'h3C) begin errors++; $display("FAIL mid_qa_last got %h want 3c", bus.qa); end
      checks++; if (bus.frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_frame_cnt got %0d want 0", bus.frame_cnt); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_ping_pong();
      test_simultaneous();
      test_spurious_done();
      test_random_stream();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
